// File: rtl/req_rsp_pkg.sv
// Shared widths and default constants for the request/response loopback bridge.
package req_rsp_pkg;

  localparam int DATA_WIDTH_DEFAULT      = 32;
  localparam int COUNT_WIDTH             = 16;
  localparam int NUM_REQ_DEFAULT         = 16;
  localparam int FIFO_DEPTH_DEFAULT      = 4;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/req_rsp_loopback_bridge_fifo.sv
// Synchronous response FIFO; pointers carry one extra wrap bit to tell full from empty.
module rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/req_rsp_loopback_bridge.sv
// Traffic endpoint: issues SEED+n requests, checks echoed responses in order, reports status.
module req_rsp_loopback_bridge
  import req_rsp_pkg::*;
#(
  parameter int                    DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] SEED            = '0,
  parameter int                    NUM_REQ         = NUM_REQ_DEFAULT,
  parameter int                    FIFO_DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int                    MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_data,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  done,
  output logic                  error,
  output logic [COUNT_WIDTH-1:0] rsp_count
);

  localparam count_t NUM_REQ_C = count_t'(NUM_REQ);
  localparam count_t MAX_OUT_C = count_t'(MAX_OUTSTANDING);

  logic                  run;
  count_t                issued;
  count_t                checked;
  count_t                outstanding;
  logic                  error_q;
  logic                  done_q;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Handshake outputs depend only on registered state so a direct loopback has no comb loop.
  assign req_valid = run && (issued < NUM_REQ_C) && (outstanding < MAX_OUT_C);
  assign req_data  = run ? SEED + DATA_WIDTH'(issued) : '0;
  assign rsp_ready = run && !fifo_full;
  assign req_fire  = req_valid && req_ready;
  assign push      = rsp_valid && rsp_ready;
  assign pop       = !fifo_empty;
  assign done      = done_q;
  assign error     = error_q;
  assign rsp_count = checked;

  rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rsp_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      issued      <= '0;
      checked     <= '0;
      outstanding <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (req_fire) issued <= issued + count_t'(1);
      if (pop) begin
        checked <= checked + count_t'(1);
        if (fifo_data != SEED + DATA_WIDTH'(checked)) error_q <= 1'b1;
      end
      // A same-edge request transfer makes a loopback echo legitimate, not unsolicited.
      if (push && (((outstanding == '0) && !req_fire) || done_q)) error_q <= 1'b1;
      case ({req_fire, pop})
        2'b10:   outstanding <= outstanding + count_t'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - count_t'(1);
        default: outstanding <= outstanding;
      endcase
      if (checked == NUM_REQ_C) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_req_rsp_loopback_bridge.sv
// Bench: decoupled default bridge driven by a scoreboard model, plus a wrapped-seed loopback instance.
module tb_req_rsp_loopback_bridge;
  import req_rsp_pkg::*;

  localparam int          DW    = 32;
  localparam int          NUM   = 16;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 4;
  localparam logic [31:0] SEED  = 32'h0000_0000;
  localparam logic [31:0] SEED2 = 32'hFFFF_FFFE;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, done, error;
  logic [31:0] req_data, rsp_data;
  logic [15:0] rsp_count;

  logic        w_reset, w_req_valid, w_rsp_ready, w_done, w_error;
  logic [31:0] w_req_data;
  logic [15:0] w_rsp_count;
  logic [31:0] w_seen[$];

  int checks = 0;
  int errors = 0;

  int          m_issued, m_count;
  bit          m_run, m_done, m_error;
  logic [31:0] m_fifo[$];

  req_rsp_loopback_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .error(error), .rsp_count(rsp_count)
  );

  req_rsp_loopback_bridge #(
    .DATA_WIDTH(32), .SEED(SEED2), .NUM_REQ(4), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)
  ) dut_wrap (
    .clock(clock), .reset(w_reset),
    .req_valid(w_req_valid), .req_ready(w_rsp_ready), .req_data(w_req_data),
    .rsp_valid(w_req_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_req_data),
    .done(w_done), .error(w_error), .rsp_count(w_rsp_count)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(negedge clock) begin
    if (!w_reset && w_req_valid && w_rsp_ready) w_seen.push_back(w_req_data);
  end

  function automatic logic [31:0] item(input int n);
    return SEED + 32'(n);
  endfunction

  function automatic bit mReqValid();
    return m_run && (m_issued < NUM) && ((m_issued - m_count) < MAXO);
  endfunction

  function automatic bit mRspReady();
    return m_run && (m_fifo.size() < DEPTH);
  endfunction

  task automatic modelReset();
    m_issued = 0; m_count = 0;
    m_run = 0; m_done = 0; m_error = 0;
    m_fifo.delete();
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("req_valid", {31'b0, req_valid}, {31'b0, mReqValid()});
    checkValue("req_data", req_data, m_run ? item(m_issued) : 32'h0);
    checkValue("rsp_ready", {31'b0, rsp_ready}, {31'b0, mRspReady()});
    checkValue("done", {31'b0, done}, {31'b0, m_done});
    checkValue("error", {31'b0, error}, {31'b0, m_error});
    checkValue("rsp_count", {16'b0, rsp_count}, 32'(m_count));
  endtask

  // One clock cycle: check, drive inputs, advance the model across the coming edge.
  task automatic cycleStep(input bit rdy, input bit rv, input logic [31:0] rd,
                           output bit fired, output bit pushed);
    int          old_count;
    bit          old_done;
    logic [31:0] v;
    checkOutput();
    req_ready = rdy; rsp_valid = rv; rsp_data = rd;
    fired     = mReqValid() && rdy;
    pushed    = rv && mRspReady();
    old_count = m_count;
    old_done  = m_done;
    if (m_fifo.size() > 0) begin
      v = m_fifo.pop_front();
      if (v !== item(old_count)) m_error = 1;
      m_count++;
    end
    if (pushed) begin
      if (((m_issued - old_count) == 0 && !fired) || old_done) m_error = 1;
      m_fifo.push_back(rd);
    end
    if (old_count == NUM) m_done = 1;
    if (fired) m_issued++;
    m_run = 1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    modelReset();
    #1 checkOutput();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // delay==0 echoes as a loopback wire; otherwise a delayed in-order responder.
  task automatic applyStimulus(input int cycles, input int delay, input int stall,
                               input bit rand_mode, input int corrupt_idx);
    logic [31:0] pend_data[$];
    int          pend_due[$];
    int          rsp_idx = 0;
    int          last_due = 0;
    int          due;
    bit          rdy, rv, fired, pushed;
    logic [31:0] rd;
    for (int c = 0; c < cycles; c++) begin
      rdy = (c >= stall) && (!rand_mode || ($urandom_range(0, 3) != 0));
      if (delay == 0) begin
        rdy = rdy && rsp_ready;
        rv  = req_valid && rdy;
        rd  = req_data;
      end else begin
        rv = (pend_due.size() > 0) && (pend_due[0] <= c) && (!rand_mode || $urandom_range(0, 1) == 1);
        rd = (pend_data.size() > 0) ? pend_data[0] : 32'h0;
      end
      if (rsp_idx == corrupt_idx) rd = rd + 32'd1;
      cycleStep(rdy, rv, rd, fired, pushed);
      if (pushed) begin
        rsp_idx++;
        if (delay != 0) begin
          void'(pend_data.pop_front());
          void'(pend_due.pop_front());
        end
      end
      if (fired && delay != 0) begin
        due = c + delay + (rand_mode ? int'($urandom_range(0, 3)) : 0);
        if (due < last_due) due = last_due;
        last_due = due;
        pend_data.push_back(item(m_issued - 1));
        pend_due.push_back(due);
      end
    end
  endtask

  task automatic expectFinished(input string tag, input bit exp_error);
    checkOutput();
    checkValue({tag, "_done"}, {31'b0, done}, 32'd1);
    checkValue({tag, "_error"}, {31'b0, error}, {31'b0, exp_error});
    checkValue({tag, "_count"}, {16'b0, rsp_count}, 32'd16);
    checkValue({tag, "_idle"}, {31'b0, req_valid}, 32'd0);
  endtask

  initial begin
    bit fired, pushed;
    reset = 1'b1; w_reset = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    modelReset();
    #50 checkOutput();
    #50 reset = 1'b0; w_reset = 1'b0;

    $display("[TB] loopback with defaults");
    applyStimulus(22, 0, 0, 0, -1);
    expectFinished("loopback", 1'b0);
    $display("[TB] response after done");
    cycleStep(1'b0, 1'b1, item(NUM), fired, pushed);
    checkOutput();
    checkValue("late_rsp_error", {31'b0, error}, 32'd1);

    $display("[TB] request backpressure");
    doReset();
    applyStimulus(28, 0, 5, 0, -1);
    expectFinished("backpressure", 1'b0);

    $display("[TB] corrupt echo on third item");
    doReset();
    applyStimulus(24, 0, 0, 0, 2);
    expectFinished("corrupt", 1'b1);

    $display("[TB] delayed responder hits outstanding limit");
    doReset();
    applyStimulus(100, 10, 0, 0, -1);
    expectFinished("delayed", 1'b0);

    $display("[TB] random ready loopback");
    doReset();
    applyStimulus(80, 0, 0, 1, -1);
    expectFinished("rand_loop", 1'b0);

    $display("[TB] random delayed responder");
    doReset();
    applyStimulus(200, 3, 0, 1, -1);
    expectFinished("rand_delay", 1'b0);

    $display("[TB] unsolicited response");
    doReset();
    cycleStep(1'b0, 1'b0, 32'h0, fired, pushed);
    cycleStep(1'b0, 1'b1, 32'h0, fired, pushed);
    cycleStep(1'b0, 1'b0, 32'h0, fired, pushed);
    checkOutput();
    checkValue("unsolicited_error", {31'b0, error}, 32'd1);

    $display("[TB] reset mid-stream");
    doReset();
    for (int i = 0; i < 30 && m_issued < 7; i++)
      cycleStep(rsp_ready, req_valid && rsp_ready, req_data, fired, pushed);
    checkValue("midstream_reached7", 32'(m_issued), 32'd7);
    #3 reset = 1'b1;
    req_ready = 1'b0; rsp_valid = 1'b0;
    modelReset();
    #1 checkOutput();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(24, 0, 0, 0, -1);
    expectFinished("restart", 1'b0);

    $display("[TB] wrapped seed instance");
    checkValue("wrap_done", {31'b0, w_done}, 32'd1);
    checkValue("wrap_error", {31'b0, w_error}, 32'd0);
    checkValue("wrap_count", {16'b0, w_rsp_count}, 32'd4);
    checkValue("wrap_items", 32'(w_seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkValue("wrap_data", (i < w_seen.size()) ? w_seen[i] : 32'hDEAD_BEEF, SEED2 + 32'(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
